// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : VR16 fetch stage - PC, imem req/ack, prefetch FIFO, JUMP redirect.
//            Define INSTRUCTION_FETCH_HALT_EN to stop fetching after opcode 1111.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [15:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [15:0]           instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  halted
);

    localparam int                    PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                    CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]      c_DEPTH  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_PC_ONE = ADDR_WIDTH'(1);
    localparam logic [PTR_W-1:0]      c_PTR_ONE = PTR_W'(1);
`ifdef INSTRUCTION_FETCH_HALT_EN
    localparam logic [3:0]            c_HALT_OP = 4'b1111;
`endif

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                r_state, w_state_n;
    logic [CNT_W-1:0]      r_count, w_count_n;
    logic                  r_pend, w_pend_n;
    logic [ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_n;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
    logic [PTR_W-1:0]      r_rd_ptr, r_wr_ptr;
    logic [15:0]           r_fifo_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [15:0]           r_last_instr;
    logic [ADDR_WIDTH-1:0] r_last_pc;
    logic                  w_ack, w_push, w_pop;

    // An ack only counts against a request we actually have outstanding.
    assign w_ack  = imem_ack & r_pend;
    assign w_push = w_ack & (r_state == ST_FETCH) & ~redirect_valid;
    assign w_pop  = instr_valid & instr_ready;

    assign imem_req    = r_pend;
    assign imem_addr   = r_addr;
    assign instr_valid = (r_count != '0);
    assign instruction = instr_valid ? r_fifo_instr[r_rd_ptr] : r_last_instr;
    assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr]    : r_last_pc;

`ifdef INSTRUCTION_FETCH_HALT_EN
    assign halted = (r_state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        w_state_n    = r_state;
        w_count_n    = r_count;
        w_fetch_pc_n = r_fetch_pc;
        w_pend_n     = r_pend & ~imem_ack;
        w_addr_n     = r_addr;

        if (redirect_valid) begin
            w_count_n    = '0;
            w_fetch_pc_n = redirect_addr;
            w_state_n    = (r_pend && !imem_ack) ? ST_DRAIN : ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    w_count_n = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
                    if (w_push) begin
                        w_fetch_pc_n = r_fetch_pc + c_PC_ONE;
`ifdef INSTRUCTION_FETCH_HALT_EN
                        if (imem_rdata[15:12] == c_HALT_OP) begin
                            w_state_n = ST_HALT;
                        end
`endif
                    end
                end
                ST_DRAIN: begin
                    w_count_n = r_count - CNT_W'(w_pop);
                    if (w_ack) begin
                        w_state_n = ST_FETCH;
                    end
                end
                default: begin
                    w_count_n = r_count - CNT_W'(w_pop);
                end
            endcase
        end

        // In-flight requests reserve a slot, so a push can never overflow.
        if ((w_state_n == ST_FETCH) && !w_pend_n && (w_count_n < c_DEPTH)) begin
            w_pend_n = 1'b1;
            w_addr_n = w_fetch_pc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FETCH;
            r_count      <= '0;
            r_pend       <= 1'b0;
            r_fetch_pc   <= RESET_PC;
            r_addr       <= RESET_PC;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_last_instr <= '0;
            r_last_pc    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_count    <= w_count_n;
            r_pend     <= w_pend_n;
            r_fetch_pc <= w_fetch_pc_n;
            r_addr     <= w_addr_n;
            if (redirect_valid) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            // Remember the presented head so an empty FIFO keeps showing it.
            if (instr_valid) begin
                r_last_instr <= instruction;
                r_last_pc    <= instr_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Scoreboard bench for instruction_fetch (memory model + decoder).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    typedef struct packed {
        logic [11:0] pc;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        redirect_valid;
    logic [11:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instruction;
    logic [11:0] instr_pc;
    logic        halted;

    logic [15:0] mem [4096];
    exp_t        sb_q [$];
    exp_t        head;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          ack_delay    = 0;
    int          wait_cnt     = 0;
    int          ack_cnt      = 0;
    int          addr5_cnt    = 0;
    logic        hold_en      = 1'b0;
    logic [11:0] hold_addr    = 12'h0;
    logic        prev_pend    = 1'b0;
    logic [11:0] prev_addr    = 12'h0;
    logic        drain        = 1'b0;

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_addr(input logic [11:0] a, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == a) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // Memory responder and decoder-side scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            imem_ack  = 1'b0;
            wait_cnt  = 0;
            drain     = 1'b0;
            prev_pend = 1'b0;
            sb_q.delete();
        end else begin
            if (prev_pend) begin
                check("req_hold", 32'(imem_req), 32'd1);
                check("addr_hold", 32'(imem_addr), 32'(prev_addr));
            end
            imem_ack = 1'b0;
            if (imem_req) begin
                if (imem_addr == 12'h005) addr5_cnt++;
                if (!(hold_en && imem_addr == hold_addr) && wait_cnt >= ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                    wait_cnt   = 0;
                    ack_cnt++;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end

            if (instr_valid && instr_ready) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    head = sb_q.pop_front();
                    check("instr_pc", 32'(instr_pc), 32'(head.pc));
                    check("instruction", 32'(instruction), 32'(head.data));
                end
            end

            if (redirect_valid) begin
                sb_q.delete();
                drain = imem_req && !imem_ack;
            end else if (imem_ack) begin
                if (drain) drain = 1'b0;
                else       sb_q.push_back(exp_t'({imem_addr, imem_rdata}));
            end

            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
        end
    end

    initial begin
        int a0;
        bit seen;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 + 16'(i);
        reset          = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 12'h0;

        // Reset values and startup
        do_reset();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        tick();
        check("start_req", 32'(imem_req), 32'd1);
        check("start_addr", 32'(imem_addr), 32'd0);
        tick();
        check("first_valid", 32'(instr_valid), 32'd1);
        check("first_instr", 32'(instruction), 32'h1000);
        check("first_pc", 32'(instr_pc), 32'd0);
        check("b2b_addr1", 32'(imem_addr), 32'd1);
        tick();
        check("b2b_addr2", 32'(imem_addr), 32'd2);
        repeat (8) tick();

        // Decoder stall fills the FIFO
        instr_ready = 1'b0;
        do_reset();
        a0 = ack_cnt;
        repeat (3) tick();
        check("stall_head_mid", 32'(instruction), 32'h1000);
        repeat (3) tick();
        check("stall_acks", 32'(ack_cnt - a0), 32'd2);
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_valid", 32'(instr_valid), 32'd1);
        check("stall_pc", 32'(instr_pc), 32'd0);
        check("stall_instr", 32'(instruction), 32'h1000);
        instr_ready = 1'b1;
        repeat (8) tick();

        // Slow memory
        ack_delay = 3;
        repeat (20) tick();
        ack_delay = 0;
        repeat (4) tick();

        // Redirect with a stale request outstanding
        hold_addr = 12'h003;
        hold_en   = 1'b1;
        do_reset();
        wait_addr(12'h003, "reach_003");
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 12'h0A5;
        tick();
        redirect_valid = 1'b0;
        check("redir_valid", 32'(instr_valid), 32'd0);
        check("drain_req", 32'(imem_req), 32'd1);
        check("drain_addr", 32'(imem_addr), 32'h003);
        tick();
        check("drain_addr2", 32'(imem_addr), 32'h003);
        hold_en = 1'b0;
        tick();
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", 32'(imem_addr), 32'h0A5);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (instr_valid) seen = 1'b1;
            else tick();
        end
        check("redir_seen", 32'(seen), 32'd1);
        check("redir_first_pc", 32'(instr_pc), 32'h0A5);
        repeat (4) tick();

        // PC wrap
        redirect_valid = 1'b1;
        redirect_addr  = 12'hFFE;
        tick();
        redirect_valid = 1'b0;
        wait_addr(12'hFFF, "reach_fff");
        tick();
        check("wrap_req", 32'(imem_req), 32'd1);
        check("wrap_addr", 32'(imem_addr), 32'h000);
        repeat (6) tick();

        // HALT opcode
        mem[4] = 16'hF000;
        do_reset();
        a0 = addr5_cnt;
        repeat (12) tick();
`ifdef INSTRUCTION_FETCH_HALT_EN
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_no_addr5", 32'(addr5_cnt - a0), 32'd0);
        check("halt_req", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_addr  = 12'h010;
        tick();
        redirect_valid = 1'b0;
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_req", 32'(imem_req), 32'd1);
        check("unhalt_addr", 32'(imem_addr), 32'h010);
        repeat (6) tick();
`else
        check("nohalt_halted", 32'(halted), 32'd0);
        check("nohalt_addr5", 32'(addr5_cnt != a0), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
